// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared definitions for the PS/2 host-side blocks: FSM state encoding,
// frame length and default timing constants.
// No ports (package).
// Optional build macro used by users of this package: PS2_TX_GLITCH_FILTER_EN.

package ps2_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_INHIBIT   = 4'd1;
    localparam logic [3:0] S_RTS       = 4'd2;
    localparam logic [3:0] S_WAIT_CLK  = 4'd3;
    localparam logic [3:0] S_DATA      = 4'd4;
    localparam logic [3:0] S_ACK       = 4'd5;
    localparam logic [3:0] S_WAIT_IDLE = 4'd6;
    localparam logic [3:0] S_DONE      = 4'd7;
    localparam logic [3:0] S_ERR       = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE      = S_IDLE,
        ST_INHIBIT   = S_INHIBIT,
        ST_RTS       = S_RTS,
        ST_WAIT_CLK  = S_WAIT_CLK,
        ST_DATA      = S_DATA,
        ST_ACK       = S_ACK,
        ST_WAIT_IDLE = S_WAIT_IDLE,
        ST_DONE      = S_DONE,
        ST_ERR       = S_ERR
    } ps2_state_t;

    // Device falling edges in one host-to-device frame, counting the start
    // edge and the ACK edge.
    localparam int FRAME_EDGES = 11;

    localparam int DEF_INHIBIT_CYCLES = 6000;
    localparam int DEF_TIMEOUT_CYCLES = 750000;
    localparam int TMO_W              = 20;

    // Parity bit that makes data plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// ps2_line_sync
// Two-flop synchronizer for one open-drain PS/2 line, optional stability
// filter and falling-edge strobe. Used once per PS/2 pin.
// Build macro: PS2_TX_GLITCH_FILTER_EN - when defined, instances with
// FILTER_EN=1 only change level after 8 consecutive equal samples.
// Ports:
//   i_clk   - system clock
//   i_reset - synchronous active-high reset
//   i_pin   - raw pin value (asynchronous)
//   o_level - synchronized (and optionally filtered) level
//   o_fall  - one-cycle strobe on a 1->0 transition of o_level

module ps2_line_sync #(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit USE_FILTER = FILTER_EN;
`else
    localparam bit USE_FILTER = FILTER_EN & 1'b0;
`endif

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic w_level;

    // Idle bus is high; reset to 1 so leaving reset never fakes a fall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
        end
    end

    generate
        if (USE_FILTER) begin : g_filter
            logic       r_filt;
            logic [2:0] r_run;

            // r_run counts consecutive samples that disagree with r_filt;
            // the eighth one commits the new level.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_filt <= 1'b1;
                    r_run  <= 3'd0;
                end else if (r_sync == r_filt) begin
                    r_run <= 3'd0;
                end else if (r_run == 3'd7) begin
                    r_filt <= r_sync;
                    r_run  <= 3'd0;
                end else begin
                    r_run <= r_run + 3'd1;
                end
            end

            assign w_level = r_filt;
        end else begin : g_direct
            assign w_level = r_sync;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_fall  = r_prev & ~w_level;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter: sends one command byte to the keyboard
// over the shared open-drain CLK/DAT pins.
// Build macro: PS2_TX_GLITCH_FILTER_EN - adds an 8-sample stability filter on
// the synchronized CLK line (see ps2_line_sync).
// Ports:
//   CLOCK_50 - system clock, all logic on its rising edge
//   RESET    - synchronous active-high reset
//   TX_DATA  - byte to send, latched when TX_START is accepted
//   TX_START - one-cycle request, accepted only while TX_BUSY=0
//   TX_BUSY  - transfer in progress (through the DONE/ERR cycle)
//   TX_DONE  - one-cycle pulse: device ACKed and bus returned idle
//   TX_ERROR - one-cycle pulse: timeout or missing ACK
//   PS2_CLK  - open-drain clock pin (drives 0 or Z)
//   PS2_DAT  - open-drain data pin (drives 0 or Z)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | pins released, waiting for TX_START
// INHIBIT   | CLK held low for INHIBIT_CYCLES
// RTS       | one cycle: DAT low (start bit), CLK released
// WAIT_CLK  | waiting for the device's first falling CLK edge
// DATA      | presenting data bits, parity and stop on each falling edge
// ACK       | sampling the device ACK on the next falling edge
// WAIT_IDLE | waiting for CLK=1 and DAT=1
// DONE      | one cycle, TX_DONE=1
// ERR       | one cycle, TX_ERROR=1, pins released

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERROR,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam logic [TMO_W-1:0] INH_LOAD = 20'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = 20'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_EDGES - 2);

    ps2_state_t       r_state;
    logic             r_clk_oe;
    logic             r_dat_oe;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [9:0]       r_shift;
    logic [3:0]       r_bitcnt;
    logic [TMO_W-1:0] r_inh_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_dat_lvl;
    logic w_dat_fall_unused;

    ps2_line_sync #(.FILTER_EN(1'b1)) u_clk_sync (
        .i_clk   (CLOCK_50),
        .i_reset (RESET),
        .i_pin   (PS2_CLK),
        .o_level (w_clk_lvl),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync #(.FILTER_EN(1'b0)) u_dat_sync (
        .i_clk   (CLOCK_50),
        .i_reset (RESET),
        .i_pin   (PS2_DAT),
        .o_level (w_dat_lvl),
        .o_fall  (w_dat_fall_unused)
    );

    // Open-drain: only ever pull low or release.
    assign PS2_CLK = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = r_dat_oe ? 1'b0 : 1'bz;

    assign TX_BUSY  = r_busy;
    assign TX_DONE  = r_done;
    assign TX_ERROR = r_error;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_shift   <= '1;
            r_bitcnt  <= 4'd0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= TMO_LOAD;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            // Free-running down-count; every wait-state entry and every
            // device falling edge below overrides this with a reload.
            if (r_tmo_cnt != '0) begin
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (TX_START) begin
                        r_shift   <= {1'b1, odd_parity(TX_DATA), TX_DATA};
                        r_bitcnt  <= 4'd0;
                        r_inh_cnt <= INH_LOAD;
                        r_clk_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= ST_INHIBIT;
                    end
                end

                // Falls seen here come from our own CLK pull-down or a
                // device fighting it; both are deliberately ignored.
                ST_INHIBIT: begin
                    if (r_inh_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_state  <= ST_RTS;
                    end else begin
                        r_inh_cnt <= r_inh_cnt - 1'b1;
                    end
                end

                ST_RTS: begin
                    r_tmo_cnt <= TMO_LOAD;
                    r_state   <= ST_WAIT_CLK;
                end

                ST_WAIT_CLK: begin
                    if (w_clk_fall) begin
                        r_dat_oe  <= ~r_shift[0];
                        r_bitcnt  <= 4'd1;
                        r_tmo_cnt <= TMO_LOAD;
                        r_state   <= ST_DATA;
                    end else if (r_tmo_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= ST_ERR;
                    end
                end

                // r_bitcnt holds the number of falling edges already seen;
                // the edge that puts the stop bit (a release) on the line
                // hands over to ACK.
                ST_DATA: begin
                    if (w_clk_fall) begin
                        r_shift   <= {1'b1, r_shift[9:1]};
                        r_dat_oe  <= ~r_shift[1];
                        r_bitcnt  <= r_bitcnt + 4'd1;
                        r_tmo_cnt <= TMO_LOAD;
                        if (r_bitcnt == LAST_BIT) begin
                            r_state <= ST_ACK;
                        end
                    end else if (r_tmo_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= ST_ERR;
                    end
                end

                ST_ACK: begin
                    if (w_clk_fall) begin
                        if (!w_dat_lvl) begin
                            r_tmo_cnt <= TMO_LOAD;
                            r_state   <= ST_WAIT_IDLE;
                        end else begin
                            r_clk_oe <= 1'b0;
                            r_dat_oe <= 1'b0;
                            r_error  <= 1'b1;
                            r_state  <= ST_ERR;
                        end
                    end else if (r_tmo_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= ST_ERR;
                    end
                end

                ST_WAIT_IDLE: begin
                    if (w_clk_lvl && w_dat_lvl) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_tmo_cnt == '0) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_error  <= 1'b1;
                        r_state  <= ST_ERR;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_ERR: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TMO  = 300;
    localparam int HALF = 50;   // device clock half-period in system cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    wire        ps2_clk, ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .TX_DATA  (din),
        .TX_START (start),
        .TX_BUSY  (busy),
        .TX_DONE  (done),
        .TX_ERROR (err),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit both_seen = 1'b0;
    logic [9:0] sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        if (done === 1'b1 && err === 1'b1) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d, input bit push);
        logic [9:0] f;
        @(negedge clk);
        din   = d;
        start = 1'b1;
        if (push) begin
            f = {1'b1, ($countones(d) % 2 == 0), d};
            sb.push_back(f);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("clk_inhibit_low", ps2_clk, 0);
    endtask

    task automatic wait_release(output int rel_cyc);
        int k = 0;
        while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && k < 10 * INH) begin
            @(negedge clk);
            k++;
        end
        chk("inhibit_len", k, INH);
        rel_cyc = cyc;
    endtask

    // Behavioural keyboard: nfall falling edges, data read just before each
    // rising edge, optional ACK driven after the 10th rising edge, optional
    // short low glitch in the high phase after edge glitch_at.
    task automatic dev_frame(input int nfall, input bit do_ack, input int glitch_at,
                             output logic [9:0] rx);
        rx = '0;
        repeat (5) @(negedge clk);
        for (int i = 1; i <= nfall; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i <= 10) rx[i-1] = ps2_dat;
            dev_clk_low = 1'b0;
            if (i == 10 && do_ack) dev_dat_low = 1'b1;
            if (i == glitch_at) begin
                repeat (HALF / 2) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF - HALF / 2 - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [9:0] rx);
        logic [9:0] e;
        chk({tag, "_sb_depth"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_frame"}, rx, e);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err_none"}, err, 0);
        @(negedge clk);
        chk({tag, "_busy_low"}, busy, 0);
        chk({tag, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        logic [9:0] rx;
        int rel, k, d0, e0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_clk_z", ps2_clk, 1);
        chk("rst_dat_z", ps2_dat, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED, 0x01, 0xFF with ACK
        start_tx(8'hED, 1'b1);
        wait_release(rel);
        dev_frame(11, 1'b1, 0, rx);
        check_frame("ed", rx);
        wait_done("ed");

        start_tx(8'h01, 1'b1);
        wait_release(rel);
        dev_frame(11, 1'b1, 0, rx);
        chk("par_01", rx[8], 0);
        check_frame("x01", rx);
        wait_done("x01");

        start_tx(8'hFF, 1'b1);
        wait_release(rel);
        dev_frame(11, 1'b1, 0, rx);
        chk("par_ff", rx[8], 1);
        check_frame("xff", rx);
        wait_done("xff");

        // Device never clocks
        d0 = done_cnt;
        start_tx(8'hA5, 1'b0);
        wait_release(rel);
        k = 0;
        while (err !== 1'b1 && k < TMO + 50) begin
            @(negedge clk);
            k++;
        end
        chk("tmo_err_seen", err, 1);
        chk("tmo_latency", cyc - rel, TMO + 1);
        @(negedge clk);
        chk("tmo_clk_z", ps2_clk, 1);
        chk("tmo_dat_z", ps2_dat, 1);
        chk("tmo_busy_low", busy, 0);
        chk("tmo_no_done", done_cnt - d0, 0);

        // Device omits ACK
        repeat (10) @(negedge clk);
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h12, 1'b1);
        wait_release(rel);
        dev_frame(11, 1'b0, 0, rx);
        check_frame("noack", rx);
        repeat (20) @(negedge clk);
        chk("noack_err_cnt", err_cnt - e0, 1);
        chk("noack_no_done", done_cnt - d0, 0);
        chk("noack_busy_low", busy, 0);

        // Second start during the data phase is ignored
        repeat (10) @(negedge clk);
        start_tx(8'hF4, 1'b1);
        wait_release(rel);
        fork
            dev_frame(11, 1'b1, 0, rx);
            begin
                repeat (300) @(negedge clk);
                din   = 8'h55;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_frame("busy_f4", rx);
        wait_done("busy_f4");
        repeat (50) @(negedge clk);
        chk("no_queue_busy", busy, 0);
        chk("no_queue_clk", ps2_clk, 1);

        // Reset at bit 4
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h00, 1'b0);
        wait_release(rel);
        dev_frame(5, 1'b0, 0, rx);
        chk("rst_bit4_driven", ps2_dat, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_dat_z", ps2_dat, 1);
        chk("midrst_clk_z", ps2_clk, 1);
        chk("midrst_busy", busy, 0);
        rst = 1'b0;
        repeat (TMO + 100) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_err", err_cnt - e0, 0);
        chk("midrst_idle", busy, 0);

`ifdef PS2_TX_GLITCH_FILTER_EN
        // Short CLK glitch during DATA is filtered out
        start_tx(8'hC3, 1'b1);
        wait_release(rel);
        dev_frame(11, 1'b1, 4, rx);
        check_frame("glitch", rx);
        wait_done("glitch");
`endif

        chk("no_done_err_overlap", both_seen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
